// File: rtl/depth_tester_if.sv
// Fragment-in / framebuffer-out bus of the depth tester.
// The master side produces fragments and clear requests; the slave side is the depth tester.
interface depth_tester_if;
    logic             clear_in;
    logic             ready_out;
    logic             valid_in;
    logic [2:0][16:0] fragment_in;
    logic [11:0]      color_in;
    logic             fb_we_out;
    logic [16:0]      fb_addr_out;
    logic [11:0]      fb_data_out;

    modport master (
        output clear_in, valid_in, fragment_in, color_in,
        input  ready_out, fb_we_out, fb_addr_out, fb_data_out
    );

    modport slave (
        input  clear_in, valid_in, fragment_in, color_in,
        output ready_out, fb_we_out, fb_addr_out, fb_data_out
    );
endinterface

// File: rtl/depth_tester.sv
// Z-buffer depth tester: 4-cycle compare pipeline with write forwarding and a full-screen depth clear.
// Define DEPTH_TESTER_STATS_EN to add pass/fail/drop counters as extra outputs.
module depth_tester #(
    parameter int unsigned SCREEN_WIDTH  = 320,
    parameter int unsigned SCREEN_HEIGHT = 240
) (
    input  logic          clk_in,
    input  logic          rst_in,
    depth_tester_if.slave bus
`ifdef DEPTH_TESTER_STATS_EN
    ,
    output logic [31:0]   passed_count_out,
    output logic [31:0]   failed_count_out,
    output logic [31:0]   dropped_count_out
`endif
);
    localparam int unsigned PIX_N   = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int unsigned ADDR_W  = 17;
    localparam int unsigned Z_W     = 17;
    localparam int unsigned COL_W   = 12;
    localparam int unsigned COORD_W = 9;
    localparam int unsigned IDX_W   = (PIX_N > 1) ? $clog2(PIX_N) : 1;
    localparam int unsigned PIPE_N  = 4;
    localparam int unsigned HIST_N  = 3;
    localparam logic [Z_W-1:0] Z_FAR = '1;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_CLEAR} state_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic [Z_W-1:0]    z;
        logic [COL_W-1:0]  color;
    } frag_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] addr;
        logic [Z_W-1:0]    z;
    } hist_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              ready_q, ready_d;
    frag_t             pipe_q [PIPE_N];
    frag_t             pipe_d [PIPE_N];
    hist_t             hist_q [HIST_N];
    hist_t             hist_d [HIST_N];
    logic [Z_W-1:0]    rd1_q, rd1_d, rd2_q, rd2_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [COL_W-1:0]  fb_data_q, fb_data_d;

    logic [Z_W-1:0]     depth_mem [PIX_N];
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [Z_W-1:0]     mem_wdata;
    logic [COORD_W-1:0] pix_x, pix_y;
    logic               in_range, accept, pipe_busy, pass, fwd_hit;
    logic [Z_W-1:0]     stored_z;
    logic               frac_unused;

    assign frac_unused = ^{bus.fragment_in[0][7:0], bus.fragment_in[1][7:0]};

    // Fragment intake: integer pixel coordinates and screen bounds check.
    always_comb begin
        pix_x    = bus.fragment_in[0][16:8];
        pix_y    = bus.fragment_in[1][16:8];
        in_range = (32'(pix_x) < SCREEN_WIDTH) && (32'(pix_y) < SCREEN_HEIGHT);
        accept   = bus.valid_in && ready_q && in_range;
    end

    // Pipeline, 2-cycle depth read, compare against newest depth (pending writes take priority).
    always_comb begin
        pipe_d[0].vld   = accept;
        pipe_d[0].addr  = ADDR_W'(pix_y) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(pix_x);
        pipe_d[0].z     = bus.fragment_in[2];
        pipe_d[0].color = bus.color_in;
        for (int i = 1; i < PIPE_N; i++) pipe_d[i] = pipe_q[i-1];

        pipe_busy = 1'b0;
        for (int i = 0; i < PIPE_N; i++) pipe_busy = pipe_busy | pipe_q[i].vld;

        rd1_d = depth_mem[IDX_W'(pipe_q[1].addr)];
        rd2_d = rd1_q;

        stored_z = rd2_q;
        fwd_hit  = 1'b0;
        for (int i = 0; i < HIST_N; i++) begin
            if (!fwd_hit && hist_q[i].vld && (hist_q[i].addr == pipe_q[PIPE_N-1].addr)) begin
                fwd_hit  = 1'b1;
                stored_z = hist_q[i].z;
            end
        end
        pass = pipe_q[PIPE_N-1].vld && (pipe_q[PIPE_N-1].z < stored_z);

        hist_d[0].vld  = pass;
        hist_d[0].addr = pipe_q[PIPE_N-1].addr;
        hist_d[0].z    = pipe_q[PIPE_N-1].z;
        for (int i = 1; i < HIST_N; i++) hist_d[i] = hist_q[i-1];

        fb_we_d   = pass;
        fb_addr_d = pipe_q[PIPE_N-1].addr;
        fb_data_d = pipe_q[PIPE_N-1].color;

        mem_we    = pass;
        mem_waddr = pipe_q[PIPE_N-1].addr;
        mem_wdata = pipe_q[PIPE_N-1].z;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = Z_FAR;
        end
    end

    // Run -> Drain on clear request, Drain -> Clear once the pipeline is empty, Clear sweeps all pixels.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            ST_RUN: begin
                if (bus.clear_in) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!pipe_busy) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_q == ADDR_W'(PIX_N - 1)) begin
                    state_d    = ST_RUN;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_CLEAR;
        endcase
        ready_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            for (int i = 0; i < PIPE_N; i++) pipe_q[i] <= '0;
            for (int i = 0; i < HIST_N; i++) hist_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ready_q    <= ready_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            pipe_q     <= pipe_d;
            hist_q     <= hist_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (mem_we) depth_mem[IDX_W'(mem_waddr)] <= mem_wdata;
    end

    assign bus.ready_out   = ready_q;
    assign bus.fb_we_out   = fb_we_q;
    assign bus.fb_addr_out = fb_addr_q;
    assign bus.fb_data_out = fb_data_q;

`ifdef DEPTH_TESTER_STATS_EN
    logic [31:0] passed_q, passed_d, failed_q, failed_d, dropped_q, dropped_d;

    // Event counters survive depth clears; only reset zeroes them.
    always_comb begin
        passed_d  = passed_q + 32'(pass);
        failed_d  = failed_q + 32'(pipe_q[PIPE_N-1].vld && !pass);
        dropped_d = dropped_q + 32'(bus.valid_in && !accept);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            passed_q  <= '0;
            failed_q  <= '0;
            dropped_q <= '0;
        end else begin
            passed_q  <= passed_d;
            failed_q  <= failed_d;
            dropped_q <= dropped_d;
        end
    end

    assign passed_count_out  = passed_q;
    assign failed_count_out  = failed_q;
    assign dropped_count_out = dropped_q;
`endif
endmodule
